// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: M-extension ALU control codes, operand width and
// the multiply/divide sequencer state encoding.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_MUL    = 5'b01011;
    localparam logic [4:0] ALU_MULH   = 5'b01100;
    localparam logic [4:0] ALU_MULHSU = 5'b01101;
    localparam logic [4:0] ALU_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b01111;
    localparam logic [4:0] ALU_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_REM    = 5'b10001;
    localparam logic [4:0] ALU_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_mdu(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic op_is_div(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic op_a_signed(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: 32-cycle shift-add multiplier / restoring divider
// sharing one 64-bit accumulator and one negator for sign correction.
module muldiv_sequencer
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state_reg, state_next;
    logic [4:0]      op_reg, op_next;
    logic            sa_reg, sa_next;
    logic            sb_reg, sb_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic [63:0]     acc_reg, acc_next;
    logic [31:0]     opnd_reg, opnd_next;
    logic [31:0]     result_reg, result_next;

    logic            accept;
    logic            a_neg, b_neg;
    logic [31:0]     a_abs, b_abs;
    logic [32:0]     mul_sum;
    logic [32:0]     rem_sh;
    logic [33:0]     rem_diff;
    logic            res_sign;
    logic [63:0]     fix_src, fix_val;
    logic [31:0]     fix_word;

    assign accept = start && !kill && op_is_mdu(alu_ctrl);
    assign a_neg  = op_a_signed(alu_ctrl) && op_a[31];
    assign b_neg  = op_b_signed(alu_ctrl) && op_b[31];
    assign a_abs  = a_neg ? (32'd0 - op_a) : op_a;
    assign b_abs  = b_neg ? (32'd0 - op_b) : op_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    // Divide: acc = {remainder, dividend/quotient bits}, shifted left.
    assign rem_sh   = acc_reg[63:31];
    assign rem_diff = {1'b0, rem_sh} - {2'b00, opnd_reg};

    always_comb begin
        res_sign = 1'b0;
        case (op_reg)
            ALU_MUL, ALU_MULH, ALU_DIV: res_sign = sa_reg ^ sb_reg;
            ALU_MULHSU, ALU_REM:        res_sign = sa_reg;
            default:                    res_sign = 1'b0;
        endcase
    end

    // Divide results are narrowed to one word before negation so quotient and
    // remainder are corrected independently through the same 64-bit negator.
    always_comb begin
        fix_src = acc_reg;
        if (op_is_div(op_reg)) begin
            if (op_reg == ALU_DIV || op_reg == ALU_DIVU)
                fix_src = {32'd0, acc_reg[31:0]};
            else
                fix_src = {32'd0, acc_reg[63:32]};
        end
        fix_val  = res_sign ? (64'd0 - fix_src) : fix_src;
        fix_word = (op_reg == ALU_MUL || op_is_div(op_reg)) ? fix_val[31:0] : fix_val[63:32];
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next  = alu_ctrl;
                    sa_next  = a_neg;
                    sb_next  = b_neg;
                    cnt_next = 5'd0;
                    if (op_is_div(alu_ctrl)) begin
                        acc_next  = {32'd0, a_abs};
                        opnd_next = b_abs;
                        if (op_b == 32'd0) begin
                            state_next  = DONE;
                            result_next = (alu_ctrl == ALU_DIV || alu_ctrl == ALU_DIVU)
                                          ? 32'hFFFF_FFFF : op_a;
                        end else begin
                            state_next = ITER;
                        end
                    end else begin
                        acc_next   = {32'd0, b_abs};
                        opnd_next  = a_abs;
                        state_next = ITER;
                    end
                end
            end
            ITER: begin
                if (op_is_div(op_reg)) begin
                    if (!rem_diff[33])
                        acc_next = {rem_diff[31:0], acc_reg[30:0], 1'b1};
                    else
                        acc_next = {rem_sh[31:0], acc_reg[30:0], 1'b0};
                end else begin
                    acc_next = {mul_sum, acc_reg[31:1]};
                end
                cnt_next = cnt_reg + 5'd1;
                if (kill)
                    state_next = IDLE;
                else if (cnt_reg == 5'd31)
                    state_next = FIX;
            end
            FIX: begin
                if (kill) begin
                    state_next = IDLE;
                end else begin
                    result_next = fix_word;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= 5'd0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            cnt_reg    <= 5'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            result_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            result_reg <= result_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule
